// File: rtl/chess_board_writer_if.sv
// rtl/chess_board_writer_if.sv - command and board-memory bus bundle for chess_board_writer
//
// Purpose: groups the command handshake and the single-port memory bus.
// Signals:
//   cmd_valid/cmd_ready        command handshake
//   cmd_op/cmd_sq_a/cmd_sq_b   command opcode and squares {row, col}
//   cmd_mark                   mark colour
//   mem_addr/mem_we/mem_wdata  memory request
//   mem_rdata                  memory read data, one cycle after address
//   done/err                   completion pulse and reject qualifier
// Modports: slave = writer engine, master = command source plus memory.
interface chess_board_writer_if #(
  parameter int MEM_AW = 12
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [5:0]        cmd_sq_a;
  logic [5:0]        cmd_sq_b;
  logic [1:0]        cmd_mark;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              done;
  logic              err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_sq_a, cmd_sq_b, cmd_mark, mem_rdata,
    output cmd_ready, mem_addr, mem_we, mem_wdata, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_sq_a, cmd_sq_b, cmd_mark, mem_rdata,
    input  cmd_ready, mem_addr, mem_we, mem_wdata, done, err
  );
endinterface

// File: rtl/chess_board_writer.sv
// rtl/chess_board_writer.sv - write-side engine for the VGA chess board memory
//
// Purpose: executes INIT / MOVE / MARK commands as single-port memory
// read/write sequences producing the square and turn words the display decodes.
// Ports:
//   iCLK    system clock, rising edge
//   iRST_n  synchronous active-low reset
//   bus     chess_board_writer_if.slave (command handshake, memory bus, done/err)
// All outputs are registered.
module chess_board_writer #(
  parameter int TURN_ADDR = 66,
  parameter int MEM_AW    = 12
) (
  input  logic                 iCLK,
  input  logic                 iRST_n,
  chess_board_writer_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_WR, S_RD_A, S_RD_A_WAIT, S_WR_DST,
    S_WR_SRC, S_RD_TURN, S_TURN_WAIT, S_WR_TURN, S_MARK_WR
  } state_t;

  localparam logic [1:0]        OP_INIT = 2'd0;
  localparam logic [1:0]        OP_MOVE = 2'd1;
  localparam logic [1:0]        OP_MARK = 2'd2;
  localparam logic [MEM_AW-1:0] L_TURN  = MEM_AW'(TURN_ADDR);
  localparam logic [MEM_AW-1:0] L_LAST  = MEM_AW'(63);

  state_t            r_state;
  logic              r_ready;
  logic              r_we;
  logic [MEM_AW-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_done;
  logic              r_err;
  logic [1:0]        r_op;
  logic [5:0]        r_a;
  logic [5:0]        r_b;
  logic [1:0]        r_mark;

  // One-hot square colour nibble: dark when row+col is even.
  function automatic logic [3:0] base_nib(input logic [5:0] sq);
    return (sq[3] ^ sq[0]) ? 4'h4 : 4'h8;
  endfunction

  function automatic logic [MEM_AW-1:0] sq_addr(input logic [5:0] sq);
    return {{(MEM_AW-6){1'b0}}, sq};
  endfunction

  // Starting position word for a square.
  function automatic logic [31:0] init_word(input logic [5:0] sq);
    logic [2:0] back;
    logic [2:0] ptype;
    case (sq[2:0])
      3'd0, 3'd7: back = 3'd5;
      3'd1, 3'd6: back = 3'd1;
      3'd2, 3'd5: back = 3'd4;
      3'd3:       back = 3'd3;
      default:    back = 3'd2;
    endcase
    case (sq[5:3])
      3'd0, 3'd7: ptype = back;
      3'd1, 3'd6: ptype = 3'd6;
      default:    ptype = 3'd0;
    endcase
    return {24'b0, base_nib(sq), ptype, (sq[5:4] == 2'b11)};
  endfunction

  function automatic logic [3:0] mark_nib(input logic [1:0] mark, input logic [5:0] sq);
    case (mark)
      2'd1:    return 4'h2;
      2'd2:    return 4'h1;
      default: return base_nib(sq);
    endcase
  endfunction

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_mark  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (r_ready && bus.cmd_valid) begin
            r_op   <= bus.cmd_op;
            r_a    <= bus.cmd_sq_a;
            r_b    <= bus.cmd_sq_b;
            r_mark <= bus.cmd_mark;
            if (bus.cmd_op == OP_INIT) begin
              r_ready <= 1'b0;
              r_state <= S_INIT_WR;
              r_we    <= 1'b1;
              r_addr  <= '0;
              r_wdata <= init_word(6'd0);
            end else if ((bus.cmd_op == OP_MOVE && bus.cmd_sq_a != bus.cmd_sq_b) ||
                         (bus.cmd_op == OP_MARK && bus.cmd_mark != 2'd3)) begin
              r_ready <= 1'b0;
              r_state <= S_RD_A;
              r_addr  <= sq_addr(bus.cmd_sq_a);
            end else begin
              // Rejected without touching memory; stays ready for a new command.
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end
          end
        end
        S_INIT_WR: begin
          if (r_addr == L_TURN) begin
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_addr == L_LAST) begin
            r_addr  <= L_TURN;
            r_wdata <= '0;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_wdata <= init_word(6'(r_addr[5:0] + 6'd1));
          end
        end
        S_RD_A: r_state <= S_RD_A_WAIT;
        S_RD_A_WAIT: begin
          if (r_op == OP_MOVE) begin
            if (bus.mem_rdata[3:1] == 3'd0) begin
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              // Destination keeps only the moved piece; any occupant is overwritten.
              r_state <= S_WR_DST;
              r_we    <= 1'b1;
              r_addr  <= sq_addr(r_b);
              r_wdata <= {24'b0, base_nib(r_b), bus.mem_rdata[3:0]};
            end
          end else begin
            r_state <= S_MARK_WR;
            r_we    <= 1'b1;
            r_wdata <= {24'b0, mark_nib(r_mark, r_a), bus.mem_rdata[3:0]};
          end
        end
        S_WR_DST: begin
          r_state <= S_WR_SRC;
          r_addr  <= sq_addr(r_a);
          r_wdata <= {24'b0, base_nib(r_a), 4'b0};
        end
        S_WR_SRC: begin
          r_state <= S_RD_TURN;
          r_we    <= 1'b0;
          r_addr  <= L_TURN;
        end
        S_RD_TURN: r_state <= S_TURN_WAIT;
        S_TURN_WAIT: begin
          r_state <= S_WR_TURN;
          r_we    <= 1'b1;
          r_wdata <= {31'b0, ~bus.mem_rdata[0]};
        end
        S_WR_TURN, S_MARK_WR: begin
          r_we    <= 1'b0;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_we    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_ready;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_chess_board_writer.sv
// tb/tb_chess_board_writer.sv - self-checking bench for chess_board_writer
module tb_chess_board_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chess_board_writer_if #(.MEM_AW(12)) bus();

  chess_board_writer #(.TURN_ADDR(66), .MEM_AW(12)) dut (
    .iCLK  (clk),
    .iRST_n(rst_n),
    .bus   (bus)
  );

  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic [31:0] mem [0:127];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[6:0]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[6:0]];
  end

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string            name;
    int               op;
    int               a;
    int               b;
    int               mark;
    int               err;
    int               done_cyc;
    int               nwr;
    logic [2:0][7:0]  wc;
    logic [2:0][11:0] wa;
    logic [2:0][31:0] wd;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Expected starting word, computed arithmetically from the piece layout.
  function automatic logic [31:0] exp_init(input int sq);
    int row;
    int col;
    int t;
    row = sq / 8;
    col = sq % 8;
    t = 0;
    if (row == 0 || row == 7) begin
      case (col)
        0, 7: t = 5;
        1, 6: t = 1;
        2, 5: t = 4;
        3:    t = 3;
        default: t = 2;
      endcase
    end else if (row == 1 || row == 6) begin
      t = 6;
    end
    return (((row + col) % 2 == 0) ? 32'h80 : 32'h40) + 32'(t * 2) + ((row >= 6) ? 32'd1 : 32'd0);
  endfunction

  task automatic push(input int c, input int a, input logic [31:0] d);
    wr_t w;
    w.cyc = c;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic watch_cycle(input int c, input string tag);
    wr_t w;
    if (bus.mem_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s unexpected_write: cycle %0d addr %0d data 0x%08h, none expected",
                 tag, c, bus.mem_addr, bus.mem_wdata);
      end else begin
        w = exp_q.pop_front();
        chk({tag, " wr_cycle"}, 32'(c), 32'(w.cyc));
        chk({tag, " wr_addr"}, 32'(bus.mem_addr), 32'(w.addr));
        chk({tag, " wr_data"}, bus.mem_wdata, w.data);
      end
    end
  endtask

  // Called at a negedge; leaves at the negedge of the oDONE cycle so the
  // next call is accepted in that same cycle.
  task automatic run_cmd(input string tag, input int op, input int a, input int b,
                         input int mark, input int exp_err, input int done_cyc);
    bit got;
    chk({tag, " ready_at_issue"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_op    = 2'(op);
    bus.cmd_sq_a  = 6'(a);
    bus.cmd_sq_b  = 6'(b);
    bus.cmd_mark  = 2'(mark);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    got = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      watch_cycle(c, tag);
      if (bus.done) begin
        got = 1'b1;
        chk({tag, " done_cycle"}, 32'(c), 32'(done_cyc));
        chk({tag, " err"}, 32'(bus.err), 32'(exp_err));
        chk({tag, " ready_at_done"}, 32'(bus.cmd_ready), 32'd1);
        break;
      end else begin
        chk({tag, " ready_busy"}, 32'(bus.cmd_ready), 32'd0);
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no done within 150 cycles, want cycle %0d", tag, done_cyc);
    end
    chk({tag, " writes_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic add_vec(input string name, input int op, input int a, input int b,
                         input int mark, input int err, input int dc, input int n,
                         input int c0, input int a0, input logic [31:0] d0,
                         input int c1, input int a1, input logic [31:0] d1,
                         input int c2, input int a2, input logic [31:0] d2);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.mark = mark;
    v.err = err; v.done_cyc = dc; v.nwr = n;
    v.wc[0] = 8'(c0); v.wa[0] = 12'(a0); v.wd[0] = d0;
    v.wc[1] = 8'(c1); v.wa[1] = 12'(a1); v.wd[1] = d1;
    v.wc[2] = 8'(c2); v.wa[2] = 12'(a2); v.wd[2] = d2;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unwritten;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_sq_a  = '0;
    bus.cmd_sq_b  = '0;
    bus.cmd_mark  = '0;
    for (int i = 0; i < 128; i++) mem[i] = SENT;

    add_vec("move12_28",  1, 12, 28, 0, 0, 8, 3, 3, 28, 32'h4C, 4, 12, 32'h40, 7, 66, 32'h01);
    add_vec("move_empty", 1, 20, 36, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec("move_same",  1, 12, 12, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec("mark_red",   2, 28, 0, 1, 0, 4, 1, 3, 28, 32'h2C, 0, 0, 0, 0, 0, 0);
    add_vec("mark_green", 2, 28, 0, 2, 0, 4, 1, 3, 28, 32'h1C, 0, 0, 0, 0, 0, 0);
    add_vec("mark_base",  2, 28, 0, 0, 0, 4, 1, 3, 28, 32'h4C, 0, 0, 0, 0, 0, 0);
    add_vec("mark_rsvd",  2, 28, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec("op_rsvd",    3, 5, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec("move28_12",  1, 28, 12, 0, 0, 8, 3, 3, 12, 32'h4C, 4, 28, 32'h40, 7, 66, 32'h00);
    add_vec("capture",    1, 51, 11, 0, 0, 8, 3, 3, 11, 32'h8D, 4, 51, 32'h40, 7, 66, 32'h01);
    add_vec("move11_51",  1, 11, 51, 0, 0, 8, 3, 3, 51, 32'h4D, 4, 11, 32'h80, 7, 66, 32'h00);
    add_vec("mark_dark",  2, 0, 0, 2, 0, 4, 1, 3, 0, 32'h1A, 0, 0, 0, 0, 0, 0);

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst we",    32'(bus.mem_we), 32'd0);
    chk("rst addr",  32'(bus.mem_addr), 32'd0);
    chk("rst wdata", bus.mem_wdata, 32'd0);
    chk("rst done",  32'(bus.done), 32'd0);
    chk("rst err",   32'(bus.err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    // INIT abandoned by reset taking effect at the cycle-10 edge.
    for (int c = 1; c <= 9; c++) push(c, c - 1, exp_init(c - 1));
    bus.cmd_op = 2'd0;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      watch_cycle(c, "abort");
      chk("abort no_done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b0;
    for (int c = 10; c <= 11; c++) begin
      @(negedge clk);
      watch_cycle(c, "abort");
      chk("abort we_low", 32'(bus.mem_we), 32'd0);
      chk("abort done_low", 32'(bus.done), 32'd0);
      chk("abort ready_low", 32'(bus.cmd_ready), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort ready_after_release", 32'(bus.cmd_ready), 32'd1);
    chk("abort writes_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    unwritten = 0;
    for (int i = 9; i <= 63; i++) if (mem[i] === SENT) unwritten++;
    chk("abort unwritten_9_63", 32'(unwritten), 32'd55);
    chk("abort addr8", mem[8], 32'h4C);

    // Full INIT.
    for (int s = 0; s < 64; s++) push(s + 1, s, exp_init(s));
    push(65, 66, 32'h0);
    run_cmd("init", 0, 0, 0, 0, 0, 66);
    chk("init addr0",  mem[0],  32'h8A);
    chk("init addr1",  mem[1],  32'h42);
    chk("init addr3",  mem[3],  32'h46);
    chk("init addr4",  mem[4],  32'h84);
    chk("init addr8",  mem[8],  32'h4C);
    chk("init addr56", mem[56], 32'h4B);
    chk("init addr27", mem[27], 32'h80);
    chk("init addr66", mem[66], 32'h00);

    // Table of commands, each issued in the previous command's done cycle.
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].nwr; k++)
        push(int'(vecs[i].wc[k]), int'(vecs[i].wa[k]), vecs[i].wd[k]);
      run_cmd(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].mark,
              vecs[i].err, vecs[i].done_cyc);
    end

    @(negedge clk);
    chk("final addr66", mem[66], 32'h00);
    chk("final addr0",  mem[0],  32'h1A);
    chk("final addr12", mem[12], 32'h4C);
    chk("final addr28", mem[28], 32'h40);
    chk("final addr11", mem[11], 32'h80);
    chk("final addr51", mem[51], 32'h4D);
    chk("final addr36", mem[36], 32'h80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chess_board_writer.md
# chess_board_writer

Write-side engine for the chess board memory scanned by the VGA display path. Accepts board commands (initialise, move, mark square) over a valid/ready handshake and performs the required single-port memory reads and writes. It produces the 32-bit square words and the turn word in exactly the format the display decodes.

## Interface
- TURN_ADDR, 66: memory address of the turn word.
- MEM_AW, 12: memory address width.
- iCLK  in  1  system clock; all state changes on its rising edge.
- iRST_n  in  1  reset, synchronous, active-low.
- iCMD_VALID  in  1  command valid.
- oCMD_READY  out  1  block idle and able to accept a command.
- iCMD_OP  in  2  0 INIT, 1 MOVE, 2 MARK, 3 reserved.
- iCMD_SQ_A  in  6  square {row[2:0], col[2:0]}: MOVE source, MARK target. Row 0 is white's back rank.
- iCMD_SQ_B  in  6  MOVE destination square.
- iCMD_MARK  in  2  MARK colour: 0 base, 1 red, 2 green, 3 reserved.
- oMEM_ADDR  out  MEM_AW  memory address.
- oMEM_WE  out  1  write enable.
- oMEM_WDATA  out  32  write data.
- iMEM_RDATA  in  32  read data, valid the cycle after its address.
- oDONE  out  1  one-cycle pulse when a command completes.
- oERR  out  1  qualifies oDONE; the command was rejected.

## Operation
- Square word format:
  - bit0: piece colour (0 white, 1 black).
  - [3:1]: piece type (0 none, 1 knight, 2 king, 3 queen, 4 bishop, 5 rook, 6 pawn).
  - [7:4]: one-hot square colour (8 dark, 4 light, 2 red, 1 green).
  - [31:8]: 0.
- Square address is {6'b0, row, col}. The turn word holds the turn in bit0 (0 = white to move); other bits are 0.
- Base colour: dark (0x80) if row+col is even, else light (0x40).
- Command acceptance: iCMD_VALID && oCMD_READY at a rising edge; command fields are latched at that edge.
- States: IDLE, INIT_WR, RD_A, RD_A_WAIT, WR_DST, WR_SRC, RD_TURN, TURN_WAIT, WR_TURN, MARK_WR.
- INIT:
  - INIT_WR writes addresses 0..63, then TURN_ADDR with 0.
  - Row 0 is white R N B Q K B N R; row 1 is white pawns; rows 6 and 7 mirror these in black.
  - All other squares hold type 0. Every square gets its base colour.
- MOVE:
  - If SQ_A == SQ_B: reject immediately with no memory access.
  - RD_A: address SQ_A. RD_A_WAIT: capture the word; reject if type is 0.
  - WR_DST: write base(SQ_B) | captured[3:0] to SQ_B. This overwrites any capture.
  - WR_SRC: write base(SQ_A) to SQ_A.
  - RD_TURN, TURN_WAIT: read TURN_ADDR. WR_TURN: write {31'b0, ~rdata[0]}.
  - No legality checking is done; game rules belong to software.
- MARK:
  - RD_A, RD_A_WAIT: read SQ_A.
  - MARK_WR: write with [7:4] replaced by the colour (base, 0x20, 0x10) and [3:0] preserved.
  - iCMD_MARK == 3: reject with no access.
- OP 3: reject with no access.
- oMEM_WE is high only in write states. oMEM_ADDR and oMEM_WDATA are don't-care when no access is in progress, but must be stable.

## Timing
- All outputs are registered.
- Values while iRST_n=0: oCMD_READY=0, oMEM_WE=0, oMEM_ADDR=0, oMEM_WDATA=0, oDONE=0, oERR=0, state IDLE.
- oCMD_READY rises on the first edge with iRST_n=1 and is low from the accept edge until completion.
- Cycle 0 is the accept edge; writes commit at the end of the cycle in which oMEM_WE=1.
- INIT: writes occur in cycles 1–65; oDONE in cycle 66.
- MOVE: RD_A cycle 1, wait cycle 2, WR_DST 3, WR_SRC 4, RD_TURN 5, wait 6, WR_TURN 7, oDONE cycle 8.
- MARK: read 1, wait 2, write 3, oDONE cycle 4.
- Immediate reject: oDONE=oERR=1 in cycle 1. Empty-source reject: oDONE=oERR=1 in cycle 3, with no writes.
- In the oDONE cycle the state is IDLE and oCMD_READY=1, so a new command may be accepted in that same cycle.
- Reset mid-command: the command is abandoned, completed writes remain, no further writes occur, and no oDONE is issued.
- iCMD_VALID while busy is ignored; the command is not queued.

## Test plan
- INIT -> 65 writes in cycles 1–65, then oDONE in cycle 66. Check: addr0=0x8A, addr1=0x42, addr3=0x46, addr4=0x84, addr8=0x4C, addr56=0x4B, addr27=0x80, addr66=0x00.
- After INIT, MOVE A=12, B=28 -> cycle 3 writes 0x4C@28, cycle 4 writes 0x40@12, cycle 7 writes 0x01@66, oDONE cycle 8 with oERR=0.
- MOVE A=20 (empty) -> no oMEM_WE pulse; oDONE=oERR=1 in cycle 3. MOVE A=B=12 -> oDONE=oERR=1 in cycle 1, no access.
- MARK A=28, colour 1 on 0x4C -> writes 0x2C@28 in cycle 3. MARK colour 0 -> restores 0x4C. MARK colour 3 -> oERR in cycle 1.
- Reset asserted in INIT cycle 10 -> oMEM_WE=0 from the next edge, no oDONE, oCMD_READY=1 one edge after release, addresses 9..63 unwritten.
- Back-to-back: a MOVE accepted in the previous command's oDONE cycle -> its RD_A follows on the next cycle with no lost turn toggle (addr66 ends at 0x00 after two moves).
